digit_scan_driver: RTL and testbench
====================================

DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4; number of multiplexed digits, range 2..8.
REQ-002 Parameter SCAN_DIV, default 50000; clk cycles per scan tick, minimum 2.
REQ-003 Parameter BLINK_DIV, default 250; scan ticks per blink phase toggle, minimum 1.
REQ-004 clk  input  1; single clock, all state rising-edge.
REQ-005 rst_n  input  1; asynchronous, active-low reset.
REQ-006 value  input  4*N_DIGITS; nibble k drives digit k; digit 0 is least significant.
REQ-007 load  input  1; one-cycle strobe capturing value into the shadow register.
REQ-008 hex_mode  input  1; 1 = codes A-F shown as letters, 0 = codes 10-15 blanked.
REQ-009 digit_en  input  N_DIGITS; per-digit enable; 0 forces that digit dark.
REQ-010 blink_mask  input  N_DIGITS; digits flashed at blink rate.
REQ-011 seg  output  7; {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 an  output  N_DIGITS; digit anodes, active-low, one-hot-low or all-high, registered.
REQ-013 upd_done  output  1; one-cycle pulse when shadow is committed to the active register.

Function
REQ-014 Prescaler counts 0..SCAN_DIV-1 and wraps; a scan tick is asserted in the wrap cycle.
REQ-015 On each tick, digit index advances by 1 and wraps from N_DIGITS-1 to 0; the wrap tick is the frame boundary.
REQ-016 seg and an reflect the new index one clk after the tick; an drives low only the bit of the current index.
REQ-017 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
REQ-018 hex_mode=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; hex_mode=0: codes 10-15 give 1111111.
REQ-019 Digit blanked (seg=1111111, an all high) when digit_en bit is 0, or blink phase is 1 and blink_mask bit is 1.
REQ-020 Blink phase toggles every BLINK_DIV scan ticks; phase 0 shows all digits.
REQ-021 load=1 writes value into shadow and sets pending; repeated loads overwrite shadow, pending stays 1.
REQ-022 At frame boundary with pending=1: active<=shadow, pending<=0, upd_done=1 for exactly that one cycle.
REQ-023 load coinciding with a frame-boundary commit: commit takes the prior shadow; new value captured into shadow; pending remains 1.
REQ-024 Display always decodes from active, never shadow; no tearing within a frame.
REQ-025 hex_mode, digit_en and blink_mask are sampled live each cycle.

Reset
REQ-026 rst_n low asynchronously forces: seg=1111111, an all 1, upd_done=0, prescaler=0, index=0, blink phase=0, blink counter=0, shadow=0, active=0, pending=0.
REQ-027 Reset mid-frame or mid-pending discards the pending update; the first tick after release selects digit 1.

Configuration
REQ-028 Macro LZ_BLANK_EN defined: digits above the most significant nonzero digit of active are blanked; digit 0 is never blanked by this rule.
REQ-029 LZ_BLANK_EN undefined: no leading-zero suppression; only REQ-019 blanks digits.

Verification (N_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2)
REQ-030 Reset release, digit_en=1111, no load -> an cycles 1101,1011,0111,1110 every 4 clk; seg=1000000 throughout.
REQ-031 load value=16'h1234 mid-frame -> digits unchanged until frame wrap; upd_done one pulse; then digit0 seg=0011001, digit3 seg=1111001.
REQ-032 active=16'h00AF, hex_mode toggled 1->0 -> digit0 seg 0001110->1111111, digit1 seg 0001000->1111111.
REQ-033 blink_mask=0001, digits 0-3 enabled -> digit 0 dark for 2 ticks, lit for 2 ticks, alternating; others always lit.
REQ-034 load on frame-boundary cycle with pending set -> old shadow committed, upd_done pulses, second commit and pulse at next boundary.
REQ-035 With LZ_BLANK_EN, active=16'h0050 -> digits 3,2 dark, digit1 0010010, digit0 1000000; without macro digits 3,2 show 1000000.

Source files
------------

// File: rtl/digit_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_driver
// Brief    : Multiplexed 7-segment scanner with shadow/active update and blink.
//            Define LZ_BLANK_EN to suppress leading zeros of the active value.
// Revision : 1.0
// ============================================================================
module digit_scan_driver #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  upd_done
);

  localparam int c_PW = $clog2(SCAN_DIV);
  localparam int c_IW = $clog2(N_DIGITS);
  localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(SCAN_DIV - 1);
  localparam logic [c_IW-1:0] c_IDX_MAX   = c_IW'(N_DIGITS - 1);
  localparam logic [c_BW-1:0] c_BLINK_MAX = c_BW'(BLINK_DIV - 1);
  localparam logic [6:0]      c_SEG_OFF   = 7'b1111111;

  logic [c_PW-1:0]       r_presc;
  logic [c_IW-1:0]       r_idx;
  logic [c_BW-1:0]       r_blink_cnt;
  logic                  r_phase;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic [4*N_DIGITS-1:0] r_active;
  logic                  r_pending;
  logic [6:0]            r_seg;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_upd_done;

  logic                  w_tick;
  logic                  w_frame;
  logic                  w_commit;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg_code;
  logic [N_DIGITS-1:0]   w_an_sel;
  logic                  w_lz_blank;
  logic                  w_blank;

  assign w_tick   = (r_presc == c_PRESC_MAX);
  assign w_frame  = w_tick && (r_idx == c_IDX_MAX);
  assign w_commit = w_frame && r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
        if (r_blink_cnt == c_BLINK_MAX) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  // A load landing on the commit edge stays pending: the commit takes the old shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_commit) begin
        r_active <= r_shadow;
      end
      if (load) begin
        r_shadow  <= value;
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign w_nibble = r_active[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_seg_code = c_SEG_OFF;
    case (w_nibble)
      4'h0: w_seg_code = 7'b1000000;
      4'h1: w_seg_code = 7'b1111001;
      4'h2: w_seg_code = 7'b0100100;
      4'h3: w_seg_code = 7'b0110000;
      4'h4: w_seg_code = 7'b0011001;
      4'h5: w_seg_code = 7'b0010010;
      4'h6: w_seg_code = 7'b0000010;
      4'h7: w_seg_code = 7'b1111000;
      4'h8: w_seg_code = 7'b0000000;
      4'h9: w_seg_code = 7'b0011000;
      4'hA: w_seg_code = hex_mode ? 7'b0001000 : c_SEG_OFF;
      4'hB: w_seg_code = hex_mode ? 7'b0000011 : c_SEG_OFF;
      4'hC: w_seg_code = hex_mode ? 7'b1000110 : c_SEG_OFF;
      4'hD: w_seg_code = hex_mode ? 7'b0100001 : c_SEG_OFF;
      4'hE: w_seg_code = hex_mode ? 7'b0000110 : c_SEG_OFF;
      default: w_seg_code = hex_mode ? 7'b0001110 : c_SEG_OFF;
    endcase
  end

`ifdef LZ_BLANK_EN
  logic [c_IW-1:0] w_msd;

  // Highest nonzero digit; stays 0 for an all-zero value so digit 0 is always lit.
  always_comb begin
    w_msd = '0;
    for (int k = 1; k < N_DIGITS; k++) begin
      if (r_active[4*k +: 4] != 4'd0) begin
        w_msd = c_IW'(k);
      end
    end
  end

  assign w_lz_blank = (r_idx > w_msd);
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_an_sel        = '1;
    w_an_sel[r_idx] = 1'b0;
  end

  assign w_blank = !digit_en[r_idx] || (r_phase && blink_mask[r_idx]) || w_lz_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg      <= c_SEG_OFF;
      r_an       <= '1;
      r_upd_done <= 1'b0;
    end else begin
      r_seg      <= w_blank ? c_SEG_OFF : w_seg_code;
      r_an       <= w_blank ? '1 : w_an_sel;
      r_upd_done <= w_commit;
    end
  end

  assign seg      = r_seg;
  assign an       = r_an;
  assign upd_done = r_upd_done;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_driver
// Brief    : Directed plus randomized checks of digit_scan_driver against a
//            cycle-count based reference model. Revision : 1.0
// ============================================================================
module tb_digit_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        hex_mode;
  logic [3:0]  digit_en;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd_done;

  always #5 clk = ~clk;

  digit_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .hex_mode(hex_mode),
    .digit_en(digit_en), .blink_mask(blink_mask), .seg(seg), .an(an), .upd_done(upd_done)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n;          // clock edges since reset release
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  bit          m_pending;
  logic [6:0]  lut [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, n);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d, input logic hx);
    if (d > 4'd9 && !hx) return 7'b1111111;
    return lut[d];
  endfunction

  // Expected outputs after an edge come from the state held before that edge;
  // the tick, frame and blink schedule all follow directly from the edge count.
  task automatic cycle();
    int          t_prev, idx, ph, msd;
    bit          blank;
    logic [3:0]  d;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_upd;
    n++;
    t_prev = (n - 1) / SD;
    idx    = t_prev % N;
    ph     = (t_prev / BD) % 2;
    d      = m_active[idx*4 +: 4];
    msd    = 0;
    for (int k = 1; k < N; k++) if (m_active[k*4 +: 4] != 4'd0) msd = k;
    blank = !digit_en[idx] || (ph == 1 && blink_mask[idx]);
`ifdef LZ_BLANK_EN
    if (idx > msd) blank = 1'b1;
`endif
    e_seg = blank ? 7'b1111111 : seg_of(d, hex_mode);
    e_an  = blank ? 4'b1111 : ~(4'b0001 << idx);
    e_upd = 1'b0;
    if (n % SD == 0 && (n / SD) % N == 0 && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
      e_upd     = 1'b1;
    end
    if (load) begin
      m_shadow  = value;
      m_pending = 1'b1;
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("an", 32'(an), 32'(e_an));
    check("upd_done", 32'(upd_done), 32'(e_upd));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  // Advance until the next edge has the given position within a 16-edge frame.
  task automatic align(input int pos);
    for (int i = 0; i < SD * N && ((n + 1) % (SD * N)) != pos; i++) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_upd", 32'(upd_done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    n         = 0;
    m_shadow  = '0;
    m_active  = '0;
    m_pending = 1'b0;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    cycle();
    load  = 1'b0;
  endtask

  initial begin
    lut[0]  = 7'b1000000; lut[1]  = 7'b1111001; lut[2]  = 7'b0100100; lut[3]  = 7'b0110000;
    lut[4]  = 7'b0011001; lut[5]  = 7'b0010010; lut[6]  = 7'b0000010; lut[7]  = 7'b1111000;
    lut[8]  = 7'b0000000; lut[9]  = 7'b0011000; lut[10] = 7'b0001000; lut[11] = 7'b0000011;
    lut[12] = 7'b1000110; lut[13] = 7'b0100001; lut[14] = 7'b0000110; lut[15] = 7'b0001110;

    rst_n = 1'b1; value = '0; load = 1'b0; hex_mode = 1'b1;
    digit_en = 4'hF; blink_mask = 4'h0; n = 0;
    m_shadow = '0; m_active = '0; m_pending = 1'b0;

    do_reset();
    run(40);                       // free scan of zeros

    align(6);
    pulse_load(16'h1234);          // mid-frame load, commit at next wrap
    run(40);

    pulse_load(16'h00AF);
    run(24);
    hex_mode = 1'b0;
    run(20);
    hex_mode = 1'b1;

    blink_mask = 4'b0001;
    run(64);
    blink_mask = 4'b0000;

    pulse_load(16'h5678);          // pending set, then load on the boundary edge
    align(0);
    pulse_load(16'h9ABC);
    run(36);

    pulse_load(16'h0050);
    run(40);

    do_reset();                    // pending discarded by reset
    pulse_load(16'h4321);
    run(6);
    do_reset();
    run(24);

    for (int i = 0; i < 3000; i++) begin
      value      = 16'($urandom);
      load       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) hex_mode = ~hex_mode;
      digit_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      blink_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cycle();
      if (i == 1500) begin
        load = 1'b0;
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
